fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the execute datapath.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small queue and presents {instr, pc, pc+4} to the downstream datapath over a valid/ready handshake.
- Accepts redirects (taken branch/jump) from downstream: flushes queued instructions and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 36 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Holds the queue entry layout and the RUN/DRAIN state encoding.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response, redirect and downstream channels.
// master = fetch stage side, slave = memory/datapath side.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcplus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    output out_valid, out_instr,
    output out_pc, out_pcplus4,
    input  imem_req_ready, imem_resp_valid,
    input  imem_resp_data, redirect,
    input  redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_instr,
    input  out_pc, out_pcplus4,
    output imem_req_ready, imem_resp_valid,
    output imem_resp_data, redirect,
    output redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, power-of-2 depth.
// Head data is read straight from registered storage.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  // write the pushed word into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  // pointer and occupancy tracking; flush empties the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, credit-limited imem fetch, instruction queue.
// Optional FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_if.master      bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   w_drop_nxt;
  logic [CW-1:0]   w_sum;
  fetch_entry_t    r_last;

  logic [AW:0]     w_q_count;
  logic [AW:0]     w_pc_count;
  logic [XLEN-1:0] w_pc_head;
  fetch_entry_t    w_head;
  fetch_entry_t    w_q_wdata;
  fetch_entry_t    w_out;

  logic w_pending;
  logic w_resp_ok;
  logic w_resp_drop;
  logic w_resp_push;
  logic w_req_valid;
  logic w_req_fire;
  logic w_q_empty;
  logic w_out_valid;
  logic w_pop;

  assign w_sum = r_inflight + r_drop + CW'(w_q_count);
  assign w_pending = (r_inflight + r_drop) != '0;
  assign w_resp_ok = bus.imem_resp_valid & w_pending;
  assign w_resp_drop = w_resp_ok & (r_drop != '0);
  assign w_resp_push = w_resp_ok & (r_drop == '0)
                     & ~bus.redirect;
  assign w_req_valid = ~reset & ~bus.redirect
                     & (w_sum < CW'(DEPTH));
  assign w_req_fire = w_req_valid & bus.imem_req_ready;
  assign w_q_empty = (w_q_count == '0);
  assign w_out_valid = ~w_q_empty & ~bus.redirect;
  assign w_pop = w_out_valid & bus.out_ready;

  assign w_q_wdata = '{instr: bus.imem_resp_data,
                       pc:    w_pc_head};

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.redirect),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_resp_push),
    .o_data  (w_pc_head),
    .o_count (w_pc_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_insn_q (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.redirect),
    .i_push  (w_resp_push),
    .i_data  (w_q_wdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_q_count)
  );

  // outstanding/drop credit bookkeeping; redirect turns inflight into drops
  always_comb begin
    w_inflight_nxt = r_inflight;
    w_drop_nxt     = r_drop;
    if (bus.redirect) begin
      w_inflight_nxt = '0;
      w_drop_nxt = r_drop + r_inflight
                 + CW'(w_req_fire) - CW'(w_resp_ok);
    end else begin
      w_inflight_nxt = r_inflight + CW'(w_req_fire)
                     - CW'(w_resp_push);
      w_drop_nxt = r_drop - CW'(w_resp_drop);
    end
  end

  // RUN while nothing is to be dropped, DRAIN otherwise
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_drop_nxt != '0) w_state_nxt = DRAIN;
      DRAIN:   if (w_drop_nxt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // state, counters and program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
      if (bus.redirect)
        r_fetch_pc <= bus.redirect_pc & ~32'h3;
      else if (w_req_fire)
        r_fetch_pc <= r_fetch_pc + INSN_BYTES;
    end
  end

  // remember the last delivered entry so outputs hold when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last <= '{instr: NOP_INSN, pc: RESET_PC};
    else if (w_pop) r_last <= w_head;
  end

  assign w_out = w_q_empty ? r_last : w_head;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_instr      = w_out.instr;
  assign bus.out_pc         = w_out.pc;
  assign bus.out_pcplus4    = w_out.pc + INSN_BYTES;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  // delivered and redirect-discarded instruction counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (bus.redirect)
        r_perf_flushed <= r_perf_flushed
                        + 32'(w_q_count) + 32'(r_inflight);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

`ifndef SYNTHESIS
  // a response with nothing outstanding means the memory side misbehaved
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.imem_resp_valid && !w_pending));
      assert (CW'(w_pc_count) == r_inflight);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a latency model.
// Second instance covers the RESET_PC wrap case.
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   mem_lat;
  int   cyc_n;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
  } obs_t;

  mreq_t       mq[$];
  obs_t        out_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] acc2_q[$];

  fetch_if dif ();
  fetch_if dif2 ();

`ifdef FETCH_PERF_EN
  logic [31:0] pf1, pl1, pf2, pl2;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (pf1),
    .perf_flushed (pl1)
`endif
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (dif2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (pf2),
    .perf_flushed (pl2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] opc(input int i);
    return (i < out_q.size()) ? out_q[i].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] oin(input int i);
    return (i < out_q.size()) ? out_q[i].instr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] op4(input int i);
    return (i < out_q.size()) ? out_q[i].p4 : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc2(input int i);
    return (i < acc2_q.size()) ? acc2_q[i] : 32'hDEAD_BEEF;
  endfunction

  // memory models and monitors: sample at negedge, drive after posedge
  initial begin
    logic        s_rst, s_acc, s_rsp, s_acc2;
    logic [31:0] s_addr, s_addr2;
    mreq_t       m;
    obs_t        o;
    dif.imem_resp_valid  = 1'b0;
    dif.imem_resp_data   = '0;
    dif2.imem_resp_valid = 1'b0;
    dif2.imem_resp_data  = '0;
    cyc_n = 0;
    forever begin
      @(negedge clk);
      s_rst   = reset;
      s_acc   = dif.imem_req_valid & dif.imem_req_ready;
      s_addr  = dif.imem_req_addr;
      s_rsp   = dif.imem_resp_valid;
      s_acc2  = dif2.imem_req_valid & dif2.imem_req_ready;
      s_addr2 = dif2.imem_req_addr;
      if (!reset) begin
        if (s_acc) acc_q.push_back(s_addr);
        if (s_acc2) acc2_q.push_back(s_addr2);
        if (dif.out_valid && dif.out_ready) begin
          o.instr = dif.out_instr;
          o.pc    = dif.out_pc;
          o.p4    = dif.out_pcplus4;
          out_q.push_back(o);
        end
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (s_rst) mq.delete();
      else begin
        if (s_rsp && mq.size() > 0) void'(mq.pop_front());
        if (s_acc) begin
          m.addr = s_addr;
          m.due  = cyc_n + mem_lat - 1;
          mq.push_back(m);
        end
      end
      if (mq.size() > 0 && cyc_n >= mq[0].due) begin
        dif.imem_resp_valid = 1'b1;
        dif.imem_resp_data  = mq[0].addr + 32'h1000_0000;
      end else begin
        dif.imem_resp_valid = 1'b0;
        dif.imem_resp_data  = '0;
      end
      dif2.imem_resp_valid = s_acc2 & ~s_rst;
      dif2.imem_resp_data  = s_addr2;
    end
  end

  task automatic do_reset(input int lat);
    reset = 1'b1;
    dif.redirect = 1'b0;
    mem_lat = lat;
    cyc(2);
    acc_q.delete();
    out_q.delete();
    acc2_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 30 && acc_q.size() < n; i++) cyc(1);
    chk(tag, acc_q.size(), n);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    mem_lat = 1;
    dif.imem_req_ready  = 1'b1;
    dif.redirect        = 1'b0;
    dif.redirect_pc     = '0;
    dif.out_ready       = 1'b1;
    dif2.imem_req_ready = 1'b1;
    dif2.redirect       = 1'b0;
    dif2.redirect_pc    = '0;
    dif2.out_ready      = 1'b1;
    cyc(2);

    chk("rst_req_valid", dif.imem_req_valid, 0);
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_state", 32'(dut.r_state), 0);
    chk("rst_pc", dut.r_fetch_pc, 32'h0);
    chk("rst_pc2", dut2.r_fetch_pc, 32'hFFFF_FFF8);

    // sequential fetch, latency 1, plus the wrap instance
    do_reset(1);
    cyc(12);
    chk("t1_acc0", acc(0), 32'h0);
    chk("t1_acc1", acc(1), 32'h4);
    chk("t1_acc2", acc(2), 32'h8);
    chk("t1_pc0", opc(0), 32'h0);
    chk("t1_pc1", opc(1), 32'h4);
    chk("t1_pc2", opc(2), 32'h8);
    chk("t1_in1", oin(1), 32'h1000_0004);
    chk("t1_p4_2", op4(2), 32'hC);
    chk("t5_acc0", acc2(0), 32'hFFFF_FFF8);
    chk("t5_acc1", acc2(1), 32'hFFFF_FFFC);
    chk("t5_acc2", acc2(2), 32'h0000_0000);

    // stalled downstream fills credits then stops requesting
    dif.out_ready = 1'b0;
    do_reset(1);
    cyc(10);
    chk("t2_nacc", acc_q.size(), 2);
    chk("t2_reqv", dif.imem_req_valid, 0);
    chk("t2_nout", out_q.size(), 0);
    chk("t2_outv", dif.out_valid, 1);
    dif.out_ready = 1'b1;
    cyc(12);
    chk("t2_pc0", opc(0), 32'h0);
    chk("t2_pc1", opc(1), 32'h4);
    chk("t2_in1", oin(1), 32'h1000_0004);
    chk("t2_pc2", opc(2), 32'h8);
    chk("t2_acc2", acc(2), 32'h8);

    // redirect with two stale responses in flight
    do_reset(3);
    wait_acc(2, "t3_wait");
    dif.redirect = 1'b1;
    dif.redirect_pc = 32'h100;
    cyc(1);
    dif.redirect = 1'b0;
    chk("t3_drop", 32'(dut.r_drop), 2);
    chk("t3_state", 32'(dut.r_state), 1);
    chk("t3_reqv", dif.imem_req_valid, 0);
    cyc(15);
    chk("t3_acc2", acc(2), 32'h100);
    chk("t3_pc0", opc(0), 32'h100);
    chk("t3_in0", oin(0), 32'h1000_0100);
    chk("t3_p4_0", op4(0), 32'h104);
    chk("t3_pc1", opc(1), 32'h104);
    chk("t3_state2", 32'(dut.r_state), 0);

    // misaligned redirect target is forced to word alignment
    do_reset(1);
    cyc(3);
    dif.redirect = 1'b1;
    dif.redirect_pc = 32'h203;
    cyc(1);
    dif.redirect = 1'b0;
    out_q.delete();
    chk("t4_addr", dif.imem_req_addr, 32'h200);
    cyc(10);
    chk("t4_pc0", opc(0), 32'h200);
    chk("t4_in0", oin(0), 32'h1000_0200);

    // back-to-back redirects: the second wins
    do_reset(1);
    cyc(4);
    dif.redirect = 1'b1;
    dif.redirect_pc = 32'h300;
    cyc(1);
    dif.redirect_pc = 32'h400;
    cyc(1);
    dif.redirect = 1'b0;
    out_q.delete();
    chk("t7_addr", dif.imem_req_addr, 32'h400);
    cyc(10);
    chk("t7_pc0", opc(0), 32'h400);
    chk("t7_pc1", opc(1), 32'h404);

    // reset while draining clears everything immediately
    do_reset(3);
    wait_acc(2, "t6_wait");
    dif.redirect = 1'b1;
    dif.redirect_pc = 32'h500;
    cyc(1);
    dif.redirect = 1'b0;
    chk("t6_drain", 32'(dut.r_state), 1);
    reset = 1'b1;
    #1;
    chk("t6_reqv", dif.imem_req_valid, 0);
    chk("t6_outv", dif.out_valid, 0);
    chk("t6_drop", 32'(dut.r_drop), 0);
    chk("t6_pc", dut.r_fetch_pc, 32'h0);
    do_reset(3);
    cyc(15);
    chk("t6_acc0", acc(0), 32'h0);
    chk("t6_pc0", opc(0), 32'h0);
    chk("t6_in0", oin(0), 32'h1000_0000);
    chk("t6_pc1", opc(1), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
